fetch_arb: RTL and testbench

//  Arbitrates the single line-fill/write-back fetch engine between the read controller (port rd_*)
//  and the write controller (port wr_*). Round-robin between the two, one transaction at a time.

---
 rtl/fetch_arb.sv | 86 ++++++++
 tb/tb_fetch_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_arb.sv
// fetch_arb: round-robin arbiter sharing one line-fill/write-back fetch engine
// between the read controller and the write controller, one transaction at a time.
module fetch_arb #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int timeout = 1024,
    localparam int tw = $clog2(list_depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_fetch_req,
    input  logic [1:0]            rd_fetch_cmd,
    input  logic [tw-1:0]         rd_fetch_tag,
    input  logic [addr_width-1:0] rd_fetch_addr,
    input  logic [addr_width-1:0] rd_fetch_addr_pre,
    output logic                  rd_fetch_gnt,
    output logic                  rd_fetch_done,
    input  logic                  wr_fetch_req,
    input  logic [1:0]            wr_fetch_cmd,
    input  logic [tw-1:0]         wr_fetch_tag,
    input  logic [addr_width-1:0] wr_fetch_addr,
    input  logic [addr_width-1:0] wr_fetch_addr_pre,
    output logic                  wr_fetch_gnt,
    output logic                  wr_fetch_done,
    output logic                  bus_req,
    output logic [1:0]            bus_cmd,
    output logic [tw-1:0]         bus_tag,
    output logic [addr_width-1:0] bus_addr,
    output logic [addr_width-1:0] bus_addr_pre,
    input  logic                  bus_gnt,
    input  logic                  bus_done,
    output logic                  busy,
    output logic                  owner,
    output logic                  timeout_err
);
    localparam int cw = timeout > 1 ? $clog2(timeout) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
    state_t state;
    logic rr_ptr, win, gnt, done;
    logic [cw-1:0] cnt;
    assign win = rd_fetch_req && wr_fetch_req ? rr_ptr : wr_fetch_req;
    assign gnt = state == ISSUE && bus_gnt;
    // a done arriving with the grant in ISSUE completes the transaction in one cycle
    assign done = bus_done && (state == WAIT_DONE || gnt);
    assign rd_fetch_gnt = gnt && !owner;
    assign wr_fetch_gnt = gnt && owner;
    assign rd_fetch_done = done && !owner;
    assign wr_fetch_done = done && owner;
    assign bus_req = state == ISSUE;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= 1'b0;
            owner <= 1'b0;
            bus_cmd <= '0;
            bus_tag <= '0;
            bus_addr <= '0;
            bus_addr_pre <= '0;
            cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rd_fetch_req || wr_fetch_req) begin
                    owner <= win;
                    bus_cmd <= win ? wr_fetch_cmd : rd_fetch_cmd;
                    bus_tag <= win ? wr_fetch_tag : rd_fetch_tag;
                    bus_addr <= win ? wr_fetch_addr : rd_fetch_addr;
                    bus_addr_pre <= win ? wr_fetch_addr_pre : rd_fetch_addr_pre;
                    state <= ISSUE;
                end
                ISSUE: if (gnt) begin
                    state <= done ? IDLE : WAIT_DONE;
                    cnt <= '0;
                end
                WAIT_DONE: begin
                    if (done) state <= IDLE;
                    if (cnt != '1) cnt <= cnt + cw'(1);
                    if (timeout != 0 && cnt == cw'(timeout - 1)) timeout_err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (done) rr_ptr <= ~owner;
        end
    end
endmodule

// File: tb/tb_fetch_arb.sv
// tb_fetch_arb: directed scoreboard bench for fetch_arb; stimulus queues expected
// gnt/done pulses and a negedge monitor pops and compares them.
module tb_fetch_arb;
    logic clk = 0, rst = 1;
    logic rd_req = 0, wr_req = 0, bus_gnt = 0, bus_done = 0;
    logic [1:0] rd_cmd = 0, wr_cmd = 0;
    logic [1:0] rd_tag = 0, wr_tag = 0;
    logic [31:0] rd_addr = 0, wr_addr = 0, rd_pre = 0, wr_pre = 0;
    logic rd_gnt, rd_done, wr_gnt, wr_done, bus_req, busy, owner, timeout_err;
    logic [1:0] bus_cmd, bus_tag;
    logic [31:0] bus_addr, bus_addr_pre;
    int cyc = 0, checks = 0, failures = 0;
    typedef struct { int cyc; logic [3:0] pulses; logic [31:0] addr; } ev_t;
    ev_t q[$];

    fetch_arb #(.addr_width(32), .list_depth(4), .timeout(8)) dut (
        .clk(clk), .rst(rst),
        .rd_fetch_req(rd_req), .rd_fetch_cmd(rd_cmd), .rd_fetch_tag(rd_tag),
        .rd_fetch_addr(rd_addr), .rd_fetch_addr_pre(rd_pre),
        .rd_fetch_gnt(rd_gnt), .rd_fetch_done(rd_done),
        .wr_fetch_req(wr_req), .wr_fetch_cmd(wr_cmd), .wr_fetch_tag(wr_tag),
        .wr_fetch_addr(wr_addr), .wr_fetch_addr_pre(wr_pre),
        .wr_fetch_gnt(wr_gnt), .wr_fetch_done(wr_done),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_tag(bus_tag),
        .bus_addr(bus_addr), .bus_addr_pre(bus_addr_pre),
        .bus_gnt(bus_gnt), .bus_done(bus_done),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] p;
        ev_t e;
        p = {wr_done, rd_done, wr_gnt, rd_gnt};
        if (p != 0) begin
            if (q.size() == 0) chk("unexpected_pulse", {60'd0, p}, 64'd0);
            else begin
                e = q.pop_front();
                chk("pulse_kind", {60'd0, p}, {60'd0, e.pulses});
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_addr", bus_addr, e.addr);
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(logic [3:0] p, logic [31:0] a);
        q.push_back('{cyc, p, a});
    endtask

    task automatic do_reset();
        rst = 1;
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_owner", owner, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_pre", bus_addr_pre, 0);
        chk("rst_err", timeout_err, 0);
        rst = 0;
    endtask

    task automatic gnt_cycle(bit own, logic [31:0] a);
        chk("bus_req_at_gnt", bus_req, 1);
        bus_gnt = 1;
        expect_ev(own ? 4'b0010 : 4'b0001, a);
        step();
        bus_gnt = 0;
        if (own) wr_req = 0; else rd_req = 0;
        chk("bus_req_wait", bus_req, 0);
        chk("addr_hold", bus_addr, a);
    endtask

    task automatic done_cycle(bit own, logic [31:0] a);
        chk("busy_before_done", busy, 1);
        bus_done = 1;
        expect_ev(own ? 4'b1000 : 4'b0100, a);
        step();
        bus_done = 0;
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        do_reset();
        // 1: single read request
        rd_req = 1; rd_cmd = 2'b01; rd_tag = 2; rd_addr = 32'h100; rd_pre = 32'h40;
        chk("t1_idle_bus_req", bus_req, 0);
        step();
        chk("t1_bus_req1", bus_req, 1);
        chk("t1_addr", bus_addr, 32'h100);
        chk("t1_pre", bus_addr_pre, 32'h40);
        chk("t1_cmd", bus_cmd, 2'b01);
        chk("t1_tag", bus_tag, 2);
        chk("t1_owner", owner, 0);
        step();
        chk("t1_bus_req2", bus_req, 1);
        step();
        gnt_cycle(0, 32'h100);
        step();
        bus_gnt = 1;
        step();
        bus_gnt = 0;
        chk("t1_stray_gnt_busy", busy, 1);
        done_cycle(0, 32'h100);
        // 2+3: contention after reset, wr payload changes while rd owns the bus
        do_reset();
        rd_req = 1; rd_addr = 32'h200; wr_req = 1; wr_cmd = 2'b10; wr_tag = 1; wr_addr = 32'h300;
        step();
        chk("t2_owner_rd", owner, 0);
        chk("t2_addr_rd", bus_addr, 32'h200);
        gnt_cycle(0, 32'h200);
        wr_addr = 32'h380;
        step();
        chk("t3_addr_hold", bus_addr, 32'h200);
        done_cycle(0, 32'h200);
        step();
        chk("t2_owner_wr", owner, 1);
        chk("t3_wr_addr", bus_addr, 32'h380);
        chk("t2_wr_cmd", bus_cmd, 2'b10);
        gnt_cycle(1, 32'h380);
        done_cycle(1, 32'h380);
        rd_req = 1; rd_addr = 32'h240; wr_req = 1; wr_addr = 32'h340;
        step();
        chk("t2_third_owner", owner, 0);
        chk("t2_third_addr", bus_addr, 32'h240);
        gnt_cycle(0, 32'h240);
        done_cycle(0, 32'h240);
        step();
        chk("t2_fourth_owner", owner, 1);
        // 4: grant and done in the same ISSUE cycle
        bus_gnt = 1; bus_done = 1;
        expect_ev(4'b1010, 32'h340);
        step();
        bus_gnt = 0; bus_done = 0; wr_req = 0;
        chk("t4_busy", busy, 0);
        chk("t4_bus_req", bus_req, 0);
        step();
        chk("t4_stays_idle", busy, 0);
        // 5: watchdog with timeout=8
        do_reset();
        rd_req = 1; rd_addr = 32'h500;
        step();
        gnt_cycle(0, 32'h500);
        step(7);
        chk("t5_err_early", timeout_err, 0);
        step();
        chk("t5_err_set", timeout_err, 1);
        step(3);
        chk("t5_err_sticky", timeout_err, 1);
        chk("t5_still_busy", busy, 1);
        done_cycle(0, 32'h500);
        chk("t5_err_after_done", timeout_err, 1);
        // 6: reset in WAIT_DONE
        do_reset();
        rd_req = 1; rd_addr = 32'h600;
        step();
        gnt_cycle(0, 32'h600);
        step();
        rst = 1;
        step();
        chk("t6_busy", busy, 0);
        chk("t6_bus_req", bus_req, 0);
        chk("t6_addr", bus_addr, 0);
        chk("t6_owner", owner, 0);
        rst = 0;
        bus_done = 1;
        step();
        bus_done = 0;
        chk("t6_late_done_busy", busy, 0);
        step(2);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
